// File: rtl/if_prefetch_queue.sv
`timescale 1ns/1ps
// if_prefetch_queue: sequential instruction prefetcher feeding the IF stage through an in-order FIFO.
// Optional macro PREFETCH_BYPASS_EN forwards a response straight to the outputs when the queue is empty.
module if_prefetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] FULL_OCC = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic          active;
   logic [CW-1:0] count, outstanding, discard, outstanding_n;
   logic [PW-1:0] wr_ptr, rd_ptr, pcq_wr, pcq_rd;
   logic [CW:0]   occ;

   logic [31:0] instr_q [DEPTH];
   logic [31:0] pc_q    [DEPTH];
   logic [31:0] pcq     [DEPTH];

   logic        grant, resp, resp_keep, fifo_valid, enq, pop;
   logic [31:0] resp_pc;

   // active keeps mem_req low in the cycle right after reset while staying a pure function of state
   assign occ      = {1'b0, count} + {1'b0, outstanding};
   assign mem_req  = active && (occ < FULL_OCC);
   assign mem_addr = fetch_pc;

   assign grant         = mem_req && mem_gnt;
   assign resp          = mem_rvalid && (outstanding != '0);
   assign resp_keep     = resp && (discard == '0) && !redirect;
   assign resp_pc       = pcq[pcq_rd];
   assign fifo_valid    = (count != '0);
   assign pop           = fifo_valid && out_ready && !redirect;
   assign outstanding_n = outstanding + CW'(grant) - CW'(resp);

   always_comb begin
      out_valid = fifo_valid;
      out_instr = fifo_valid ? instr_q[rd_ptr] : '0;
      out_pc    = fifo_valid ? pc_q[rd_ptr]    : '0;
      enq       = resp_keep;
`ifdef PREFETCH_BYPASS_EN
      if (!fifo_valid && resp_keep) begin
         out_valid = 1'b1;
         out_instr = mem_rdata;
         out_pc    = resp_pc;
         enq       = !out_ready;
      end
`endif
   end

   // Companion PC FIFO is never flushed: stale responses still retire their entry in order.
   always_ff @(posedge clk) begin
      if (grant) pcq[pcq_wr] <= fetch_pc;
      if (enq) begin
         instr_q[wr_ptr] <= mem_rdata;
         pc_q[wr_ptr]    <= resp_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         fetch_pc    <= RESET_PC;
         active      <= 1'b0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         pcq_wr      <= '0;
         pcq_rd      <= '0;
      end else begin
         active      <= 1'b1;
         outstanding <= outstanding_n;
         if (grant) pcq_wr <= pcq_wr + PW'(1);
         if (resp)  pcq_rd <= pcq_rd + PW'(1);
         if (redirect) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            discard  <= outstanding_n;
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (resp && discard != '0) discard <= discard - CW'(1);
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(enq) - CW'(pop);
         end
      end
   end

endmodule

// File: tb/tb_if_prefetch_queue.sv
`timescale 1ns/1ps
// Scoreboard bench for if_prefetch_queue: behavioural memory, directed scenarios, popping monitor.
module tb_if_prefetch_queue;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready = 1'b0;

`ifdef PREFETCH_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .n_rst(n_rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
   typedef struct { logic [31:0] addr; int unsigned due; } req_t;
   exp_t exp_q[$];
   req_t mq[$];
   int unsigned n_cmp = 0, n_err = 0, cyc = 0, lat = 1;
   bit mon_en = 1'b0;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // In-order memory: grant seen in cycle c answers in cycle c+lat.
   initial forever begin
      @(negedge clk);
      if (!n_rst) mq.delete();
      else begin
         if (mem_rvalid && mq.size() > 0) void'(mq.pop_front());
         if (mem_req && mem_gnt) mq.push_back('{addr: mem_addr, due: cyc + lat});
      end
      @(posedge clk); #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = word(mq[0].addr);
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = '0;
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en && n_rst) begin
         if (out_valid && out_ready && !redirect) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_pop: got pc %h required no further output", out_pc);
            end else begin
               e = exp_q.pop_front();
               chk("out_pc", out_pc, e.pc);
               chk("out_instr", out_instr, e.instr);
            end
         end else if (!out_valid) begin
            chk("idle_pc", out_pc, 32'h0);
            chk("idle_instr", out_instr, 32'h0);
         end
      end
   end

   task automatic next();
      @(posedge clk); #1;
   endtask

   task automatic expect_pcs(input logic [31:0] base, input int unsigned n);
      logic [31:0] pc;
      for (int unsigned i = 0; i < n; i++) begin
         pc = base + 32'(4 * i);
         exp_q.push_back('{pc: pc, instr: word(pc)});
      end
   endtask

   // Leaves the bench at the start of the first cycle in which mem_req may rise.
   task automatic do_reset();
      mon_en = 1'b0; n_rst = 1'b0; redirect = 1'b0; mem_gnt = 1'b0; out_ready = 1'b0; lat = 1;
      exp_q.delete();
      next(); next();
      n_rst = 1'b1;
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_req", 32'(mem_req), 32'h0);
      next();
   endtask

   task automatic drain(input string name, input int unsigned max);
      int unsigned k = 0;
      while (exp_q.size() != 0 && k < max) begin
         next();
         k++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: got %0d entries outstanding after %0d cycles required 0", name, exp_q.size(), k);
      end
      mon_en = 1'b0; out_ready = 1'b0; mem_gnt = 1'b0; redirect = 1'b0;
   endtask

   initial begin
      // T1: zero-wait memory streaming from reset
      do_reset();
      mem_gnt = 1'b1; out_ready = 1'b1; expect_pcs(32'h0, 4); mon_en = 1'b1;
      @(negedge clk);
      chk("t1_req", 32'(mem_req), 32'h1);
      chk("t1_addr", mem_addr, 32'h0);
      chk("t1_valid_c0", 32'(out_valid), 32'h0);
      next(); @(negedge clk);
      chk("t1_valid_c1", 32'(out_valid), 32'(BYP));
      for (int i = 0; i < 3; i++) begin
         next(); @(negedge clk);
         chk("t1_stream", 32'(out_valid), 32'h1);
      end
      drain("t1", 20);

      // T2: IF stage stalled, queue saturates, then drains in order
      do_reset();
      mem_gnt = 1'b1;
      for (int i = 0; i < 9; i++) next();
      @(negedge clk);
      chk("t2_req_full", 32'(mem_req), 32'h0);
      chk("t2_valid_full", 32'(out_valid), 32'h1);
      next();
      expect_pcs(32'h0, 5); mon_en = 1'b1; out_ready = 1'b1;
      drain("t2", 30);

      // T3: three in flight at latency 3, redirect with the first response
      do_reset();
      lat = 3; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h10;
      expect_pcs(32'h100, 3); mon_en = 1'b1;
      next(); redirect = 1'b0; mem_gnt = 1'b1;
      @(negedge clk); chk("t3_addr_10", mem_addr, 32'h10);
      next(); next();
      next(); mem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      @(negedge clk); chk("t3_addr_1c", mem_addr, 32'h1C);
      next(); redirect = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      chk("t3_addr_100", mem_addr, 32'h100);
      chk("t3_valid_flushed", 32'(out_valid), 32'h0);
      drain("t3", 40);

      // T4: redirect together with a pop and a grant for 0x20
      do_reset();
      redirect = 1'b1; redirect_pc = 32'h1C; expect_pcs(32'h200, 3); mon_en = 1'b1;
      next(); redirect = 1'b0; mem_gnt = 1'b1;
      next(); mem_gnt = 1'b0;
      next(); mem_gnt = 1'b1; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
      @(negedge clk);
      chk("t4_head_valid", 32'(out_valid), 32'h1);
      chk("t4_addr_20", mem_addr, 32'h20);
      next(); redirect = 1'b0;
      @(negedge clk);
      chk("t4_addr_200", mem_addr, 32'h200);
      chk("t4_valid_flushed", 32'(out_valid), 32'h0);
      drain("t4", 30);

      // T5: grant withheld, request held stable, redirect retargets it
      do_reset();
      redirect = 1'b1; redirect_pc = 32'h40;
      for (int i = 0; i < 2; i++) begin
         next(); redirect = 1'b0;
         @(negedge clk);
         chk("t5_req_hold", 32'(mem_req), 32'h1);
         chk("t5_addr_hold", mem_addr, 32'h40);
      end
      next(); redirect = 1'b1; redirect_pc = 32'h80;
      @(negedge clk); chk("t5_addr_pre", mem_addr, 32'h40);
      next(); redirect = 1'b0;
      @(negedge clk); chk("t5_addr_80", mem_addr, 32'h80);
      next(); expect_pcs(32'h80, 2); mon_en = 1'b1; mem_gnt = 1'b1; out_ready = 1'b1;
      drain("t5", 30);

      // T6: address wrap and redirect-to-valid latency
      do_reset();
      out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      expect_pcs(32'hFFFF_FFF8, 4); mon_en = 1'b1;
      next(); redirect = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      chk("t6_addr_f8", mem_addr, 32'hFFFF_FFF8);
      chk("t6_valid_t1", 32'(out_valid), 32'h0);
      next(); @(negedge clk);
      chk("t6_valid_t2", 32'(out_valid), 32'(BYP));
      next(); @(negedge clk);
      chk("t6_valid_t3", 32'(out_valid), 32'h1);
      chk("t6_addr_wrap", mem_addr, 32'h0000_0000);
      drain("t6", 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion required finish before 200000ns");
      $fatal(1);
   end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction prefetch unit directly upstream of the IF stage.
- Issues sequential word fetches to a request/grant/response instruction-memory port and buffers the returned instructions with their PCs in a small in-order FIFO.
- Presents the FIFO head to the IF stage with valid/ready handshaking.
- On a redirect from branch resolution it flushes the queue, restarts fetch at the new PC and discards the responses of in-flight requests.

Parameters:
- DEPTH, 4, FIFO entries and maximum number of in-flight requests; a power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset; synchronous and active-low.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
- mem_req  out  1  fetch request valid.
- mem_addr  out  32  fetch address.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
- mem_rdata  in  32  response instruction word.
- out_valid  out  1  head entry available.
- out_instr  out  32  head instruction; 0 when out_valid=0.
- out_pc  out  32  head PC; 0 when out_valid=0.
- out_ready  in  1  IF stage accepts the head this cycle.

Behaviour:
- State:
  - fetch_pc (32 bits).
  - count (0..DEPTH): FIFO entries.
  - outstanding (0..DEPTH): granted requests not yet answered.
  - discard (0..DEPTH): stale responses still to drop.
  - FIFO read and write pointers, wrapping modulo DEPTH.
- Reset (n_rst=0 at a clock edge):
  - fetch_pc=RESET_PC; count, outstanding, discard and both pointers = 0.
  - Outputs: out_valid=0, out_instr=0, out_pc=0, mem_req=0.
- Reset mid-operation: all state is cleared in that cycle regardless of other inputs. A response arriving while outstanding=0 is ignored, not enqueued.
- mem_req = (count + outstanding < DEPTH). It is combinational from state only and never depends on mem_gnt. mem_addr = fetch_pc.
- Request hold: while mem_req=1 and mem_gnt=0, mem_addr stays stable unless a redirect occurs. On redirect the pending ungranted request is abandoned and next cycle mem_addr=redirect_pc.
- Grant (mem_req and mem_gnt): outstanding+1 and fetch_pc+4. fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Response (mem_rvalid, outstanding>0): outstanding-1.
  - If discard>0: discard-1 and the data is dropped.
  - Otherwise: enqueue {mem_rdata, pc}, where pc comes from a companion PC FIFO written at grant time.
- Pop: out_valid and out_ready pops the head. Enqueue and pop in the same cycle leave count unchanged.
- Full: mem_req is never asserted in a way that lets count reach DEPTH with data still in flight. The FIFO therefore never overflows, and enqueue while full is impossible by construction.
- Empty: out_valid=0. out_ready is a don't-care.
- Redirect at cycle t, taking priority over everything else in the same cycle:
  - FIFO cleared (count=0, pointers reset); a simultaneous pop has no effect.
  - discard = outstanding (next), counting any request granted in cycle t and excluding a response consumed in cycle t, which is itself dropped.
  - fetch_pc=redirect_pc & ~3.
  - mem_req at t+1 if outstanding(next) < DEPTH.
- Latency with a zero-wait memory (gnt in the same cycle, rvalid 1 cycle later) and no stale requests: a redirect in cycle t gives request at t+1, response at t+2 and out_valid at t+3. Steady-state throughput is one instruction per cycle.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined:
  - When count=0 and a non-discarded response arrives, out_valid/out_instr/out_pc are driven directly from mem_rdata and its PC in that cycle.
  - If out_ready=1 the word is consumed and not enqueued; otherwise it is enqueued as normal.
  - Redirect-to-out_valid latency drops to t+2.
- Undefined: outputs come only from the FIFO head (t+3 latency); there is no combinational path from mem_rdata to the outputs.

Test Plan:
- Reset release, zero-wait memory returning word = addr ^ 32'hA5A5_0000, out_ready=1:
  - mem_req on the first cycle after reset with mem_addr=0.
  - out_pc sequence 0,4,8,12, one per cycle from cycle 3.
  - out_instr matches.
- out_ready=0 held for 10 cycles, DEPTH=4:
  - count saturates at 4 and mem_req drops to 0 with outstanding=0.
  - On releasing out_ready, PCs 0,4,8,12,16 pop in order with no gap or duplicate.
- Memory with 3-cycle response latency:
  - 3 requests in flight (PCs 0x10,0x14,0x18); redirect to 0x100 in the same cycle as the 0x10 response.
  - Responses for 0x10, 0x14 and 0x18 are all dropped.
  - The first out_pc after the redirect is 0x100.
- Redirect simultaneous with a pop and with a grant for PC 0x20:
  - Queue empties and discard=outstanding including the 0x20 request.
  - No 0x20 entry ever appears.
  - redirect_pc=0x203 fetches 0x200.
- mem_gnt held low for 5 cycles:
  - mem_req and mem_addr remain stable (e.g. 0x40).
  - Redirect in cycle 3 gives mem_addr=redirect_pc next cycle.
- fetch_pc=32'hFFFF_FFF8:
  - Fetched PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
  - With PREFETCH_BYPASS_EN, out_valid rises at t+2 after a redirect into an empty queue.
